// File: rtl/xfifo_reader.sv
`default_nettype none
// ============================================================================
// Module      : xfifo_reader
// Description : Read-side adapter for the dual-clock FIFO. Converts the
//               FIFO's rd_en/valid-next-cycle protocol into a registered
//               valid/ready stream backed by a 3-entry buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module xfifo_reader #(
    parameter int DATA_WIDTH  = 8,
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_WIDTH-1:0]  fifo_dout,
    input  logic                   fifo_empty,
    input  logic                   fifo_valid,
    input  logic                   fifo_underflow,
    output logic                   fifo_rd_en,
    output logic [DATA_WIDTH-1:0]  dout,
    output logic                   dout_valid,
    input  logic                   dout_ready,
    input  logic                   flush,
    output logic [COUNT_WIDTH-1:0] word_count,
    output logic                   error
);

    localparam logic [1:0] c_last_slot = 2'd2;
    localparam logic [1:0] c_full      = 2'd3;

    logic [DATA_WIDTH-1:0]  r_mem [0:2];
    logic [1:0]             r_rd_ptr;
    logic [1:0]             r_wr_ptr;
    logic [1:0]             r_occ;
    logic                   r_inflight;
    logic                   r_drop;
    logic [DATA_WIDTH-1:0]  r_dout;
    logic                   r_dout_valid;
    logic [COUNT_WIDTH-1:0] r_word_count;
    logic                   r_error;

    logic                   w_pop;
    logic                   w_push;
    logic                   w_overflow;
    logic                   w_push_ok;
    logic                   w_spurious;
    logic [1:0]             w_rd_ptr_next;
    logic [1:0]             w_wr_ptr_next;
    logic [1:0]             w_occ_next;
    logic [2:0]             w_level;
    logic [DATA_WIDTH-1:0]  w_head_next;

    function automatic logic [1:0] f_inc(input logic [1:0] p);
        return (p == c_last_slot) ? 2'd0 : p + 2'd1;
    endfunction

    always_comb begin
        w_pop      = r_dout_valid && dout_ready && !flush;
        // A word flagged by r_drop belonged to a read issued before a flush.
        w_push     = fifo_valid && !flush && !r_drop;
        w_overflow = w_push && (r_occ == c_full) && !w_pop;
        w_push_ok  = w_push && !w_overflow;
        w_spurious = fifo_valid && !r_inflight && !r_drop;

        w_rd_ptr_next = r_rd_ptr;
        w_wr_ptr_next = r_wr_ptr;
        w_occ_next    = r_occ;
        if (flush) begin
            w_rd_ptr_next = 2'd0;
            w_wr_ptr_next = 2'd0;
            w_occ_next    = 2'd0;
        end else begin
            if (w_pop)     w_rd_ptr_next = f_inc(r_rd_ptr);
            if (w_push_ok) w_wr_ptr_next = f_inc(r_wr_ptr);
            case ({w_push_ok, w_pop})
                2'b10:   w_occ_next = r_occ + 2'd1;
                2'b01:   w_occ_next = r_occ - 2'd1;
                default: w_occ_next = r_occ;
            endcase
        end

        // Incoming word bypasses into dout when it lands at the new head.
        if (w_push_ok && (r_wr_ptr == w_rd_ptr_next))
            w_head_next = fifo_dout;
        else
            w_head_next = r_mem[w_rd_ptr_next];

        w_level = {1'b0, r_occ} + {2'b00, r_inflight};
    end

    assign fifo_rd_en = !fifo_empty && !flush && !rst && (w_level <= 3'd2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) r_mem[i] <= '0;
            r_rd_ptr     <= 2'd0;
            r_wr_ptr     <= 2'd0;
            r_occ        <= 2'd0;
            r_inflight   <= 1'b0;
            r_drop       <= 1'b0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_word_count <= '0;
            r_error      <= 1'b0;
        end else begin
            if (w_push_ok) r_mem[r_wr_ptr] <= fifo_dout;
            r_rd_ptr     <= w_rd_ptr_next;
            r_wr_ptr     <= w_wr_ptr_next;
            r_occ        <= w_occ_next;
            r_inflight   <= fifo_rd_en;
            // Only a read still outstanding after the flush cycle needs dropping.
            r_drop       <= flush && r_inflight && !fifo_valid;
            r_dout       <= w_head_next;
            r_dout_valid <= (w_occ_next != 2'd0);
            if (w_pop) r_word_count <= r_word_count + 1'b1;
            r_error      <= r_error || w_spurious || fifo_underflow || w_overflow;
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign word_count = r_word_count;
    assign error      = r_error;

endmodule
`default_nettype wire
